// File: rtl/ret_stack.sv
// Subroutine return-address stack: push on CALL, pop on RET drives the top entry onto the shared bus.
// Also supports exchange (push+pop together) and sticky overflow/underflow flags.
module ret_stack #(
    parameter int W        = 8,
    parameter int DEPTH    = 4,
    parameter int PUSH_INC = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [W-1:0]  din,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    inout  wire  [W-1:0]  bus,
    output logic [W-1:0]  top,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          unf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [W-1:0] INC = W'(PUSH_INC);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  r_stk [DEPTH];
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_unf;

    logic          w_full;
    logic          w_empty;
    logic [AW-1:0] w_top_idx;
    logic [AW-1:0] w_wr_idx;
    logic [W-1:0]  w_top;
    logic [W-1:0]  w_wr_data;
    logic          w_do_push;
    logic          w_do_pop;
    logic          w_do_xchg;
    logic          w_ovf_evt;
    logic          w_unf_evt;
    logic          w_wr_en;

    assign w_full    = (r_count == DEPTH_C);
    assign w_empty   = (r_count == '0);
    assign w_top_idx = AW'(r_count - CW'(1));
    assign w_top     = w_empty ? '0 : r_stk[w_top_idx];
    assign w_wr_data = din + INC;

    // A push+pop on an empty stack degrades to a plain push and flags underflow.
    assign w_do_xchg = push & pop & ~w_empty;
    assign w_do_push = (push & ~pop & ~w_full) | (push & pop & w_empty);
    assign w_do_pop  = pop & ~push & ~w_empty;
    assign w_ovf_evt = push & ~pop & w_full;
    assign w_unf_evt = pop & w_empty;

    assign w_wr_en   = w_do_push | w_do_xchg;
    assign w_wr_idx  = w_do_xchg ? w_top_idx : AW'(r_count);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
        end
    end

    // A new error in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_evt | (r_ovf & ~clr_err);
            r_unf <= w_unf_evt | (r_unf & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_stk[w_wr_idx] <= w_wr_data;
        end
    end

    assign bus   = pop ? w_top : {W{1'bz}};
    assign top   = w_top;
    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: tb/tb_ret_stack.sv
// Directed bench for ret_stack: table of per-cycle vectors on a PUSH_INC=0 instance,
// plus hand sequences on a PUSH_INC=1 instance for increment wrap and mid-cycle clear.
module tb_ret_stack;

    localparam logic [7:0] PROBE = 8'hA5;

    typedef struct {
        logic       pu;
        logic       po;
        logic       ce;
        logic [7:0] din;
        logic [7:0] e_bus;
        logic [2:0] e_count;
        logic [7:0] e_top;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    logic clk = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Instance 0: PUSH_INC=0
    logic       clr0, push0, pop0, clr_err0, oe0;
    logic [7:0] din0, top0;
    logic [2:0] count0;
    logic       full0, empty0, ovf0, unf0;
    wire  [7:0] bus0;
    assign bus0 = oe0 ? PROBE : 8'hzz;

    // Instance 1: PUSH_INC=1
    logic       clr1, push1, pop1, clr_err1, oe1;
    logic [7:0] din1, top1;
    logic [2:0] count1;
    logic       full1, empty1, ovf1, unf1;
    wire  [7:0] bus1;
    assign bus1 = oe1 ? PROBE : 8'hzz;

    ret_stack #(.W(8), .DEPTH(4), .PUSH_INC(0)) u0 (
        .clk(clk), .clr(clr0), .din(din0), .push(push0), .pop(pop0), .clr_err(clr_err0),
        .bus(bus0), .top(top0), .count(count0), .full(full0), .empty(empty0),
        .ovf(ovf0), .unf(unf0)
    );

    ret_stack #(.W(8), .DEPTH(4), .PUSH_INC(1)) u1 (
        .clk(clk), .clr(clr1), .din(din1), .push(push1), .pop(pop1), .clr_err(clr_err1),
        .bus(bus1), .top(top1), .count(count1), .full(full1), .empty(empty1),
        .ovf(ovf1), .unf(unf1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic pu, input logic po, input logic ce,
                                input logic [7:0] din, input logic [7:0] e_bus,
                                input logic [2:0] e_count, input logic [7:0] e_top,
                                input logic e_ovf, input logic e_unf);
        vec_t v;
        v.pu = pu; v.po = po; v.ce = ce; v.din = din; v.e_bus = e_bus;
        v.e_count = e_count; v.e_top = e_top; v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    // One cycle on instance 0: drive at negedge, check the bus mid-cycle, check state after posedge.
    task automatic apply0(input vec_t v, input int idx);
        @(negedge clk);
        push0 = v.pu; pop0 = v.po; clr_err0 = v.ce; din0 = v.din; oe0 = ~v.po;
        #1;
        if (v.po) chk($sformatf("v%0d_bus", idx), 32'(bus0), 32'(v.e_bus));
        else      chk($sformatf("v%0d_busz", idx), 32'(bus0), 32'(PROBE));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_count", idx), 32'(count0), 32'(v.e_count));
        chk($sformatf("v%0d_top", idx),   32'(top0),   32'(v.e_top));
        chk($sformatf("v%0d_full", idx),  32'(full0),  32'(v.e_count == 3'd4));
        chk($sformatf("v%0d_empty", idx), 32'(empty0), 32'(v.e_count == 3'd0));
        chk($sformatf("v%0d_ovf", idx),   32'(ovf0),   32'(v.e_ovf));
        chk($sformatf("v%0d_unf", idx),   32'(unf0),   32'(v.e_unf));
    endtask

    task automatic step1(input logic pu, input logic po, input logic [7:0] d,
                         input logic [7:0] e_bus, input logic [2:0] e_count,
                         input logic [7:0] e_top, input string nm);
        @(negedge clk);
        push1 = pu; pop1 = po; din1 = d; oe1 = ~po;
        #1;
        if (po) chk({nm, "_bus"}, 32'(bus1), 32'(e_bus));
        @(posedge clk);
        #1;
        chk({nm, "_count"}, 32'(count1), 32'(e_count));
        chk({nm, "_top"},   32'(top1),   32'(e_top));
    endtask

    vec_t vecs[$];

    initial begin
        clr0 = 1'b1; push0 = 0; pop0 = 0; clr_err0 = 0; din0 = 0; oe0 = 1'b1;
        clr1 = 1'b1; push1 = 0; pop1 = 0; clr_err1 = 0; din1 = 0; oe1 = 1'b1;

        // Test 1: three pushes
        vecs.push_back(mk(1,0,0,8'd10, 8'd0, 3'd1, 8'd10, 0,0));
        vecs.push_back(mk(1,0,0,8'd20, 8'd0, 3'd2, 8'd20, 0,0));
        vecs.push_back(mk(1,0,0,8'd30, 8'd0, 3'd3, 8'd30, 0,0));
        vecs.push_back(mk(0,0,0,8'd0,  8'd0, 3'd3, 8'd30, 0,0));
        // Test 2: pop them back
        vecs.push_back(mk(0,1,0,8'd0, 8'd30, 3'd2, 8'd20, 0,0));
        vecs.push_back(mk(0,1,0,8'd0, 8'd20, 3'd1, 8'd10, 0,0));
        vecs.push_back(mk(0,1,0,8'd0, 8'd10, 3'd0, 8'd0,  0,0));
        // Test 3: fill, overflow, drain
        vecs.push_back(mk(1,0,0,8'd1,  8'd0, 3'd1, 8'd1, 0,0));
        vecs.push_back(mk(1,0,0,8'd2,  8'd0, 3'd2, 8'd2, 0,0));
        vecs.push_back(mk(1,0,0,8'd3,  8'd0, 3'd3, 8'd3, 0,0));
        vecs.push_back(mk(1,0,0,8'd4,  8'd0, 3'd4, 8'd4, 0,0));
        vecs.push_back(mk(1,0,0,8'd99, 8'd0, 3'd4, 8'd4, 1,0));
        vecs.push_back(mk(0,1,0,8'd0, 8'd4, 3'd3, 8'd3, 1,0));
        vecs.push_back(mk(0,1,0,8'd0, 8'd3, 3'd2, 8'd2, 1,0));
        vecs.push_back(mk(0,1,0,8'd0, 8'd2, 3'd1, 8'd1, 1,0));
        vecs.push_back(mk(0,1,0,8'd0, 8'd1, 3'd0, 8'd0, 1,0));
        // Test 4: underflow and clr_err priority
        vecs.push_back(mk(0,0,1,8'd0, 8'd0, 3'd0, 8'd0, 0,0));
        vecs.push_back(mk(0,1,0,8'd0, 8'd0, 3'd0, 8'd0, 0,1));
        vecs.push_back(mk(0,0,1,8'd0, 8'd0, 3'd0, 8'd0, 0,0));
        vecs.push_back(mk(0,1,1,8'd0, 8'd0, 3'd0, 8'd0, 0,1));
        vecs.push_back(mk(0,0,1,8'd0, 8'd0, 3'd0, 8'd0, 0,0));
        // Test 5: exchange
        vecs.push_back(mk(1,0,0,8'd5,  8'd0,  3'd1, 8'd5,  0,0));
        vecs.push_back(mk(1,0,0,8'd6,  8'd0,  3'd2, 8'd6,  0,0));
        vecs.push_back(mk(1,1,0,8'd77, 8'd6,  3'd2, 8'd77, 0,0));
        vecs.push_back(mk(0,1,0,8'd0,  8'd77, 3'd1, 8'd5,  0,0));
        vecs.push_back(mk(0,1,0,8'd0,  8'd5,  3'd0, 8'd0,  0,0));
        // Exchange on empty acts as push with underflow; exchange when full is legal
        vecs.push_back(mk(1,1,0,8'd9,  8'd0,  3'd1, 8'd9,  0,1));
        vecs.push_back(mk(0,0,1,8'd0,  8'd0,  3'd1, 8'd9,  0,0));
        vecs.push_back(mk(1,0,0,8'd1,  8'd0,  3'd2, 8'd1,  0,0));
        vecs.push_back(mk(1,0,0,8'd2,  8'd0,  3'd3, 8'd2,  0,0));
        vecs.push_back(mk(1,0,0,8'd3,  8'd0,  3'd4, 8'd3,  0,0));
        vecs.push_back(mk(1,1,0,8'd50, 8'd3,  3'd4, 8'd50, 0,0));
        vecs.push_back(mk(1,0,1,8'd60, 8'd0,  3'd4, 8'd50, 1,0));
        vecs.push_back(mk(0,1,0,8'd0,  8'd50, 3'd3, 8'd2,  1,0));
        vecs.push_back(mk(0,1,0,8'd0,  8'd2,  3'd2, 8'd1,  1,0));
        vecs.push_back(mk(0,1,0,8'd0,  8'd1,  3'd1, 8'd9,  1,0));
        vecs.push_back(mk(0,1,0,8'd0,  8'd9,  3'd0, 8'd0,  1,0));

        // Reset state on both instances
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_full",  32'(full0),  32'd0);
        chk("rst_top",   32'(top0),   32'd0);
        chk("rst_ovf",   32'(ovf0),   32'd0);
        chk("rst_unf",   32'(unf0),   32'd0);
        chk("rst_busz",  32'(bus0),   32'(PROBE));
        chk("rst1_count", 32'(count1), 32'd0);
        @(negedge clk);
        clr0 = 1'b0; clr1 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply0(vecs[i], i);

        // Test 6: PUSH_INC=1 with wrap at all-ones
        step1(1, 0, 8'hFF, 8'h00, 3'd1, 8'h00, "inc_ff");
        step1(1, 0, 8'h41, 8'h00, 3'd2, 8'h42, "inc_41");
        step1(0, 1, 8'h00, 8'h42, 3'd1, 8'h00, "inc_pop1");
        step1(0, 1, 8'h00, 8'h00, 3'd0, 8'h00, "inc_pop2");
        step1(1, 0, 8'd1,  8'h00, 3'd1, 8'd2,  "inc_p1");
        step1(1, 0, 8'd2,  8'h00, 3'd2, 8'd3,  "inc_p2");
        step1(1, 0, 8'd3,  8'h00, 3'd3, 8'd4,  "inc_p3");

        // Asynchronous clear between edges with pop held
        @(negedge clk);
        push1 = 1'b0; pop1 = 1'b1; oe1 = 1'b0;
        #1;
        chk("pre_clr_bus", 32'(bus1), 32'd4);
        #1;
        clr1 = 1'b1;
        #1;
        chk("clr_count", 32'(count1), 32'd0);
        chk("clr_empty", 32'(empty1), 32'd1);
        chk("clr_top",   32'(top1),   32'd0);
        chk("clr_bus0",  32'(bus1),   32'd0);
        pop1 = 1'b0; oe1 = 1'b1;
        #1;
        chk("clr_busz", 32'(bus1), 32'(PROBE));
        @(posedge clk);
        #1;
        chk("clr_hold_count", 32'(count1), 32'd0);
        chk("clr_hold_unf",   32'(unf1),   32'd0);
        @(negedge clk);
        clr1 = 1'b0;
        step1(1, 0, 8'd7, 8'h00, 3'd1, 8'd8, "post_clr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
